// File: rtl/fifo_tree_pkg.sv
// Shared constants and types for the FIFO tree merge nodes.
package fifo_tree_pkg;

  localparam int DATA_WIDTH_DEFAULT = 36;
  localparam int SKID_DEPTH = 2;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_e;

  function automatic logic [1:0] src_onehot(input src_e src);
    return (src == SRC1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/fifo_merge_node_rr_arb2.sv
// Two-request round-robin arbiter; a tie goes to the source that did not win last.
module rr_arb2
  import fifo_tree_pkg::*;
(
  input  logic [1:0] req,
  input  logic       enable,
  input  src_e       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = src_onehot(SRC0);
        2'b10:   grant = src_onehot(SRC1);
        2'b11:   grant = (last_grant == SRC0) ? src_onehot(SRC1) : src_onehot(SRC0);
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/fifo_merge_node.sv
// 2:1 round-robin merge of two upstream FIFO buffers into one downstream buffer.
// Optional per-source word counters are built when FIFO_MERGE_STATS_EN is defined.
module fifo_merge_node
  import fifo_tree_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] src0_data_i,
  input  logic                  src0_nempty_i,
  output logic                  src0_rden_o,
  input  logic [DATA_WIDTH-1:0] src1_data_i,
  input  logic                  src1_nempty_i,
  output logic                  src1_rden_o,
  input  logic                  dst_full_i,
  output logic [DATA_WIDTH-1:0] dst_data_o,
  output logic                  dst_wren_o,
`ifdef FIFO_MERGE_STATS_EN
  output logic [STAT_WIDTH-1:0] src0_count_o,
  output logic [STAT_WIDTH-1:0] src1_count_o,
`endif
  output logic                  idle_o
);

  if (DATA_WIDTH < 1 || STAT_WIDTH < 1) begin : g_param_check
    $error("fifo_merge_node: DATA_WIDTH and STAT_WIDTH must be positive");
  end

  logic                  pend;
  src_e                  pend_src;
  src_e                  last_grant;
  logic [1:0]            occ;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [DATA_WIDTH-1:0] skid_mem [SKID_DEPTH];

  logic                  drain;
  logic                  fill;
  logic [2:0]            load;
  logic                  can_issue;
  logic [1:0]            grant;
  logic [DATA_WIDTH-1:0] fill_data;

  assign drain = reset & (occ != 2'd0) & ~dst_full_i;
  assign fill  = pend;

  // Counting the word in flight and the one leaving keeps the skid at two entries at most.
  assign load      = {1'b0, occ} + {2'b00, pend} - {2'b00, drain};
  assign can_issue = (load < 3'd2);

  rr_arb2 u_arb (
    .req        ({src1_nempty_i, src0_nempty_i}),
    .enable     (can_issue & reset),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign src0_rden_o = grant[SRC0];
  assign src1_rden_o = grant[SRC1];
  assign fill_data   = (pend_src == SRC1) ? src1_data_i : src0_data_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend       <= 1'b0;
      pend_src   <= SRC0;
      last_grant <= SRC1;
    end else if (grant != 2'b00) begin
      pend       <= 1'b1;
      pend_src   <= grant[SRC1] ? SRC1 : SRC0;
      last_grant <= grant[SRC1] ? SRC1 : SRC0;
    end else begin
      pend       <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      occ <= occ + {1'b0, fill} - {1'b0, drain};
      if (fill) begin
        wr_ptr <= ~wr_ptr;
      end
      if (drain) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        skid_mem[i] <= '0;
      end
    end else if (fill) begin
      skid_mem[wr_ptr] <= fill_data;
    end
  end

  assign dst_data_o = skid_mem[rd_ptr];
  assign dst_wren_o = drain;
  assign idle_o     = ~pend & (occ == 2'd0);

`ifdef FIFO_MERGE_STATS_EN
  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      src0_count_o <= '0;
      src1_count_o <= '0;
    end else if (fill) begin
      if (pend_src == SRC0 && src0_count_o != '1) begin
        src0_count_o <= src0_count_o + 1'b1;
      end
      if (pend_src == SRC1 && src1_count_o != '1) begin
        src1_count_o <= src1_count_o + 1'b1;
      end
    end
  end
`endif

endmodule
